// File: rtl/sobel_window_filter.sv
// 3x3 Sobel edge filter over a streamed column window; SOBEL_THRESHOLD_EN selects binary thresholded output.
// Latency 3 cycles from the completing column to out_valid; no backpressure, in_valid gaps pass through as gaps.
module sobel_window_filter #(
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224,
  parameter int THRESH     = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] top,
  input  logic [7:0] middle,
  input  logic [7:0] bottom,
  output logic [7:0] pix_out,
  output logic       out_valid,
  output logic       frame_done
);

  localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;

  logic [CW-1:0]      r_col;
  logic [RW-1:0]      r_row;
  logic [7:0]         r_tl, r_ml, r_bl, r_tm, r_mm, r_bm, r_tr, r_mr, r_br;
  logic               r_win_vld, r_win_last;
  logic signed [10:0] r_gx, r_gy;
  logic               r_g_vld, r_g_last;

  logic               w_col_wrap, w_row_wrap;
  logic signed [10:0] w_gx, w_gy;
  logic [10:0]        w_ax, w_ay, w_mag;
  logic [7:0]         w_pix;

  assign w_col_wrap = (r_col == CW'(IMG_WIDTH - 1));
  assign w_row_wrap = (r_row == RW'(IMG_HEIGHT - 3));

  // Stage 1: column shift; a window exists only once two earlier columns of this row are held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_win_vld  <= 1'b0;
      r_win_last <= 1'b0;
      {r_tl, r_ml, r_bl, r_tm, r_mm, r_bm, r_tr, r_mr, r_br} <= '0;
    end else begin
      r_win_vld  <= in_valid && (r_col >= CW'(2));
      r_win_last <= in_valid && w_col_wrap && w_row_wrap;
      if (in_valid) begin
        {r_tl, r_ml, r_bl} <= {r_tm, r_mm, r_bm};
        {r_tm, r_mm, r_bm} <= {r_tr, r_mr, r_br};
        {r_tr, r_mr, r_br} <= {top, middle, bottom};
        r_col <= w_col_wrap ? '0 : r_col + CW'(1);
        if (w_col_wrap)
          r_row <= w_row_wrap ? '0 : r_row + RW'(1);
      end
    end
  end

  always_comb begin
    w_gx = $signed(({3'b0, r_tr} + {2'b0, r_mr, 1'b0} + {3'b0, r_br}) -
                   ({3'b0, r_tl} + {2'b0, r_ml, 1'b0} + {3'b0, r_bl}));
    w_gy = $signed(({3'b0, r_bl} + {2'b0, r_bm, 1'b0} + {3'b0, r_br}) -
                   ({3'b0, r_tl} + {2'b0, r_tm, 1'b0} + {3'b0, r_tr}));
  end

  // Stage 2: gradients
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gx     <= '0;
      r_gy     <= '0;
      r_g_vld  <= 1'b0;
      r_g_last <= 1'b0;
    end else begin
      r_g_vld  <= r_win_vld;
      r_g_last <= r_win_vld && r_win_last;
      if (r_win_vld) begin
        r_gx <= w_gx;
        r_gy <= w_gy;
      end
    end
  end

  always_comb begin
    w_ax  = r_gx[10] ? (~r_gx + 11'd1) : r_gx;
    w_ay  = r_gy[10] ? (~r_gy + 11'd1) : r_gy;
    w_mag = w_ax + w_ay;
`ifdef SOBEL_THRESHOLD_EN
    w_pix = (w_mag >= 11'(THRESH)) ? 8'hFF : 8'h00;
`else
    w_pix = (w_mag > 11'd255) ? 8'hFF : w_mag[7:0];
`endif
  end

  // Stage 3: output register holds its value between results
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out    <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= r_g_vld;
      frame_done <= r_g_vld && r_g_last;
      if (r_g_vld)
        pix_out <= w_pix;
    end
  end

endmodule

// File: tb/tb_sobel_window_filter.sv
// Directed bench for sobel_window_filter on a reduced 16x6 image (14x4 = 56 results per frame).
module tb_sobel_window_filter;
  localparam int W = 16;
  localparam int H = 6;
  localparam int NRES = (W - 2) * (H - 2);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] top = '0, middle = '0, bottom = '0;
  logic [7:0] pix_out;
  logic       out_valid, frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] res_q[$];
  bit         fd_q[$];
  int         fd_cnt = 0;
  int         b2b_cnt = 0;
  logic       prev_ov = 1'b0;

  sobel_window_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESH(100)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .top(top), .middle(middle), .bottom(bottom),
    .pix_out(pix_out), .out_valid(out_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) begin
      res_q.push_back(pix_out);
      fd_q.push_back(frame_done);
    end
    if (frame_done) fd_cnt++;
    if (out_valid && prev_ov) b2b_cnt++;
    prev_ov = out_valid;
  end

  task automatic drive_col(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
    @(posedge clk); #1;
    in_valid = 1'b1; top = t; middle = m; bottom = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; top = 8'hFF; middle = 8'h11; bottom = 8'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    res_q.delete(); fd_q.delete(); fd_cnt = 0; b2b_cnt = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    n_tests++; if (pix_out !== 8'd0) begin n_fail++; $display("FAIL reset_pix_out got %0d want 0", pix_out); end
    do_reset();
    repeat (3) drive_col(8'd100, 8'd0, 8'd0);
    idle(5);
    n_tests++; if (pix_out !== 8'd255) begin n_fail++; $display("FAIL reset_pre_pix got %0d want 255", pix_out); end
    do_reset();
    @(negedge clk);
    n_tests++; if (pix_out !== 8'd0) begin n_fail++; $display("FAIL reset_clears_pix got %0d want 0", pix_out); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_clears_valid got %b want 0", out_valid); end
  endtask

  task automatic test_flat();
    bit exp_v;
    do_reset();
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (i < W) begin in_valid = 1'b1; top = 8'd128; middle = 8'd128; bottom = 8'd128; end
      else in_valid = 1'b0;
      @(negedge clk);
      exp_v = (i - 3 >= 2) && (i - 3 <= W - 1);
      n_tests++;
      if (out_valid !== exp_v) begin n_fail++; $display("FAIL flat_valid[%0d] got %b want %b", i, out_valid, exp_v); end
      if (exp_v) begin
        n_tests++;
        if (pix_out !== 8'd0) begin n_fail++; $display("FAIL flat_pix[%0d] got %0d want 0", i, pix_out); end
      end
    end
  endtask

  task automatic test_step();
    logic [7:0] v, exp_p;
    do_reset();
    for (int c = 0; c < W; c++) begin
      v = (c >= 10) ? 8'd255 : 8'd0;
      drive_col(v, v, v);
    end
    idle(5);
    n_tests++;
    if (res_q.size() != W - 2) begin n_fail++; $display("FAIL step_count got %0d want %0d", res_q.size(), W - 2); end
    else begin
      for (int j = 0; j < W - 2; j++) begin
        exp_p = (j == 8 || j == 9) ? 8'd255 : 8'd0;
        n_tests++;
        if (res_q[j] !== exp_p) begin n_fail++; $display("FAIL step_pix[centre %0d] got %0d want %0d", j + 1, res_q[j], exp_p); end
      end
    end
  endtask

  task automatic test_gradient();
    logic [71:0] win [6];
    logic [7:0]  exp_p [6];
    win[0] = {8'd0, 8'd0, 8'd0,    8'd0, 8'd0, 8'd0,    8'd10, 8'd10, 8'd10};
    win[1] = {8'd0, 8'd0, 8'd0,    8'd0, 8'd0, 8'd0,    8'd25, 8'd25, 8'd25};
    win[2] = {8'd10, 8'd10, 8'd10, 8'd0, 8'd0, 8'd0,    8'd0, 8'd0, 8'd0};
    win[3] = {8'd0, 8'd0, 8'd50,   8'd0, 8'd0, 8'd50,   8'd0, 8'd0, 8'd50};
    win[4] = {8'd100, 8'd0, 8'd0,  8'd100, 8'd0, 8'd0,  8'd100, 8'd0, 8'd0};
    win[5] = {8'd0, 8'd0, 8'd0,    8'd0, 8'd0, 8'd0,    8'd0, 8'd0, 8'd30};
`ifdef SOBEL_THRESHOLD_EN
    exp_p[0] = 8'd0;  exp_p[1] = 8'd255; exp_p[2] = 8'd0;
    exp_p[3] = 8'd255; exp_p[4] = 8'd255; exp_p[5] = 8'd0;
`else
    exp_p[0] = 8'd40;  exp_p[1] = 8'd100; exp_p[2] = 8'd40;
    exp_p[3] = 8'd200; exp_p[4] = 8'd255; exp_p[5] = 8'd60;
`endif
    for (int k = 0; k < 6; k++) begin
      logic [71:0] w;
      w = win[k];
      do_reset();
      drive_col(w[71:64], w[63:56], w[55:48]);
      drive_col(w[47:40], w[39:32], w[31:24]);
      drive_col(w[23:16], w[15:8],  w[7:0]);
      idle(5);
      n_tests++;
      if (res_q.size() != 1) begin n_fail++; $display("FAIL grad_count[%0d] got %0d want 1", k, res_q.size()); end
      else begin
        n_tests++;
        if (res_q[0] !== exp_p[k]) begin n_fail++; $display("FAIL grad_pix[%0d] got %0d want %0d", k, res_q[0], exp_p[k]); end
      end
    end
  endtask

  task automatic test_gapped_frame();
    do_reset();
    for (int c = 0; c < W * (H - 2); c++) begin
      drive_col(8'(c * 7), 8'(c * 3), 8'(c * 5));
      idle(1);
    end
    idle(5);
    n_tests++; if (res_q.size() != NRES) begin n_fail++; $display("FAIL gap_count got %0d want %0d", res_q.size(), NRES); end
    n_tests++; if (fd_cnt != 1) begin n_fail++; $display("FAIL gap_frame_done_count got %0d want 1", fd_cnt); end
    n_tests++; if (b2b_cnt != 0) begin n_fail++; $display("FAIL gap_back_to_back got %0d want 0", b2b_cnt); end
    if (fd_q.size() == NRES) begin
      n_tests++;
      if (fd_q[NRES-1] !== 1'b1) begin n_fail++; $display("FAIL gap_fd_on_last got %b want 1", fd_q[NRES-1]); end
    end
    res_q.delete();
    repeat (3) drive_col(8'd1, 8'd2, 8'd3);
    idle(5);
    n_tests++; if (res_q.size() != 1) begin n_fail++; $display("FAIL gap_counters_wrapped got %0d want 1", res_q.size()); end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    for (int c = 0; c < 2 * W + 5; c++) drive_col(8'd60, 8'd90, 8'd200);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; top = 8'd250; middle = 8'd0; bottom = 8'd250;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      if (i <= 3) begin in_valid = 1'b1; top = 8'd0; middle = 8'd0; bottom = 8'd0; end
      else in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (out_valid !== (i == 6)) begin n_fail++; $display("FAIL midreset_valid[%0d] got %b want %b", i, out_valid, (i == 6)); end
    end
  endtask

  task automatic test_back_to_back();
    int ones;
    do_reset();
    for (int c = 0; c < 2 * W * (H - 2); c++) drive_col(8'(c), 8'(c + 1), 8'(c + 2));
    idle(5);
    n_tests++; if (res_q.size() != 2 * NRES) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", res_q.size(), 2 * NRES); end
    n_tests++; if (fd_cnt != 2) begin n_fail++; $display("FAIL b2b_frame_done_count got %0d want 2", fd_cnt); end
    if (fd_q.size() == 2 * NRES) begin
      ones = 0;
      foreach (fd_q[j]) if (fd_q[j]) ones++;
      n_tests++;
      if (fd_q[NRES-1] !== 1'b1 || fd_q[2*NRES-1] !== 1'b1 || ones != 2) begin
        n_fail++;
        $display("FAIL b2b_fd_spacing got fd[%0d]=%b fd[%0d]=%b ones=%0d want 1 1 2",
                 NRES - 1, fd_q[NRES-1], 2 * NRES - 1, fd_q[2*NRES-1], ones);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_step();
    test_gradient();
    test_gapped_frame();
    test_midframe_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
